cpu_control_fsm: RTL
====================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock `clk`, reset `reset_n`. Reset is asynchronous and active-low.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  3  instruction[15:13] from the decoder
- op  in  2  instruction[12:11] from the decoder
- load_ir  out  1  instruction register load enable
- load_pc  out  1  program counter load enable
- reset_pc  out  1  selects PC next value = 0
- addr_sel  out  1  1 = memory address from PC, 0 = from data-address register
- load_addr  out  1  data-address register load enable
- mem_cmd  out  2  00 none, 10 read, 01 write
- nsel  out  3  register select, decoder encoding: 001 Rn-write/Rm, 010 Rm, 100 Rd-write, 101 Rn, 110 Rd
- vsel  out  2  register-file input mux: 00 datapath_out, 01 pc, 10 sximm8, 11 mdata
- write  out  1  register-file write enable
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel, bsel  out  1 each  1 = zero A operand / sximm5 B operand
- halted  out  1  CPU stopped in HALT

Function
REQ-003 The block SHALL be a Moore FSM; every output SHALL be a function of the current state only.
REQ-004 Any output not listed for a state SHALL be 0. mem_cmd SHALL be 00 and nsel SHALL be 000 where not listed.
REQ-005 The states and their asserted outputs SHALL be:
- RST: reset_pc=1, load_pc=1
- IF1: addr_sel=1, mem_cmd=10
- IF2: addr_sel=1, mem_cmd=10, load_ir=1
- UPDPC: load_pc=1
- DECODE: no outputs
- MOVI: nsel=001, vsel=10, write=1
- GETA: nsel=101, loada=1
- GETB: nsel=010, loadb=1
- ALU: loadc=1; asel=1 when opcode=110
- CMPS: loads=1
- WRREG: nsel=100, vsel=00, write=1
- ADDR: bsel=1, loadc=1
- LADDR: load_addr=1
- MEMRD: addr_sel=0, mem_cmd=10
- LDWR: mem_cmd=10, nsel=100, vsel=11, write=1
- GETD: nsel=110, loadb=1
- PASS: asel=1, loadc=1
- MEMWR: addr_sel=0, mem_cmd=01
- HALT: halted=1
REQ-006 The fixed fetch sequence SHALL be RST->IF1->IF2->UPDPC->DECODE.
REQ-007 DECODE SHALL branch on {opcode, op}:
- 110_10 -> MOVI
- 110_00 -> GETB
- 101_00, 101_01, 101_10 -> GETA
- 101_11 (MVN) -> GETB
- 011_00 (LDR) and 100_00 (STR) -> GETA
- 111_xx -> HALT
- any other encoding -> HALT
REQ-008 Execute transitions SHALL be:
- MOVI->IF1
- GETA->GETB for ALU opcodes; GETA->ADDR for LDR/STR
- GETB->ALU for ALU and MOV-register; GETB->CMPS for CMP (101_01)
- ALU->WRREG; WRREG->IF1; CMPS->IF1
- ADDR->LADDR
- LADDR->MEMRD for LDR; LADDR->GETD for STR
- MEMRD->LDWR->IF1
- GETD->PASS->MEMWR->IF1
REQ-009 Instruction latency, counted from entry to IF1 until the next IF1, SHALL be:
- MOVI 5 cycles
- MOV-register and MVN 7 cycles
- CMP 7 cycles
- ADD/AND 8 cycles
- LDR 9 cycles
- STR 10 cycles
REQ-010 opcode and op SHALL be sampled only in DECODE and in the execute states. Changes in other states SHALL be ignored.
REQ-011 HALT SHALL be absorbing: no memory command and no register write until reset_n is asserted.
REQ-012 mem_cmd SHALL never be 11 in any state.

Reset
REQ-013 Assertion of reset_n=0 SHALL force state RST asynchronously in any state, including mid-instruction (for example MEMWR or LDWR).
REQ-014 While reset_n=0, outputs SHALL be the RST values: reset_pc=1, load_pc=1, all others 0.
REQ-015 The first rising clk edge with reset_n=1 SHALL move RST->IF1.
REQ-016 Writes, memory commands and register loads in progress SHALL be abandoned on reset; there SHALL be no partial-cycle output glitch beyond the asynchronous state change.

Verification
REQ-017 Reset, then opcode=110, op=10 held: the state sequence SHALL be RST, IF1, IF2, UPDPC, DECODE, MOVI, IF1. In MOVI, write=1, nsel=001, vsel=10.
REQ-018 ADD (101_00): GETA nsel=101 loada=1; GETB nsel=010 loadb=1; ALU loadc=1 asel=0; WRREG nsel=100 write=1. Total 8 cycles; loads=0 throughout.
REQ-019 CMP (101_01): loads=1 exactly one cycle; write=0 for the whole instruction; 7 cycles.
REQ-020 LDR (011_00): ADDR bsel=1; LADDR load_addr=1; MEMRD addr_sel=0 mem_cmd=10; LDWR vsel=11 nsel=100 write=1. STR (100_00): MEMWR mem_cmd=01 addr_sel=0 for exactly one cycle.
REQ-021 Opcode 111, or undefined opcode 000: the FSM SHALL enter HALT and set halted=1. It SHALL stay there for 20 or more cycles with mem_cmd=00, and leave only on reset_n=0.
REQ-022 reset_n driven low asynchronously in MEMWR: mem_cmd SHALL go to 00 and reset_pc to 1 before the next clk edge. After release, the next fetch SHALL start at IF1 with addr_sel=1.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Moore control sequencer for the simple CPU: fetch, decode and per-instruction
// execute states driving the datapath, register file and memory interface.
module cpu_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDPC, S_DECODE,
    S_MOVI, S_GETA, S_GETB, S_ALU, S_CMPS, S_WRREG,
    S_ADDR, S_LADDR, S_MEMRD, S_LDWR, S_GETD, S_PASS, S_MEMWR,
    S_HALT
  } state_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b10;
  localparam logic [1:0] MEM_WRITE = 2'b01;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // opcode/op are only consulted in DECODE and the execute states below.
  always_comb begin
    state_nxt = state;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    nsel      = 3'b000;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    case (state)
      S_RST: begin
        reset_pc  = 1'b1;
        load_pc   = 1'b1;
        state_nxt = S_IF1;
      end
      S_IF1: begin
        addr_sel  = 1'b1;
        mem_cmd   = MEM_READ;
        state_nxt = S_IF2;
      end
      S_IF2: begin
        addr_sel  = 1'b1;
        mem_cmd   = MEM_READ;
        load_ir   = 1'b1;
        state_nxt = S_UPDPC;
      end
      S_UPDPC: begin
        load_pc   = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case ({opcode, op})
          5'b110_10:                       state_nxt = S_MOVI;
          5'b110_00, 5'b101_11:            state_nxt = S_GETB;
          5'b101_00, 5'b101_01, 5'b101_10: state_nxt = S_GETA;
          5'b011_00, 5'b100_00:            state_nxt = S_GETA;
          default:                         state_nxt = S_HALT;
        endcase
      end
      S_MOVI: begin
        nsel      = 3'b001;
        vsel      = 2'b10;
        write     = 1'b1;
        state_nxt = S_IF1;
      end
      S_GETA: begin
        nsel      = 3'b101;
        loada     = 1'b1;
        state_nxt = (opcode == 3'b011 || opcode == 3'b100) ? S_ADDR : S_GETB;
      end
      S_GETB: begin
        nsel      = 3'b010;
        loadb     = 1'b1;
        state_nxt = ({opcode, op} == 5'b101_01) ? S_CMPS : S_ALU;
      end
      S_ALU: begin
        loadc     = 1'b1;
        asel      = (opcode == 3'b110);
        state_nxt = S_WRREG;
      end
      S_CMPS: begin
        loads     = 1'b1;
        state_nxt = S_IF1;
      end
      S_WRREG: begin
        nsel      = 3'b100;
        vsel      = 2'b00;
        write     = 1'b1;
        state_nxt = S_IF1;
      end
      S_ADDR: begin
        bsel      = 1'b1;
        loadc     = 1'b1;
        state_nxt = S_LADDR;
      end
      S_LADDR: begin
        load_addr = 1'b1;
        state_nxt = (opcode == 3'b011) ? S_MEMRD : S_GETD;
      end
      S_MEMRD: begin
        mem_cmd   = MEM_READ;
        state_nxt = S_LDWR;
      end
      S_LDWR: begin
        mem_cmd   = MEM_READ;
        nsel      = 3'b100;
        vsel      = 2'b11;
        write     = 1'b1;
        state_nxt = S_IF1;
      end
      S_GETD: begin
        nsel      = 3'b110;
        loadb     = 1'b1;
        state_nxt = S_PASS;
      end
      S_PASS: begin
        asel      = 1'b1;
        loadc     = 1'b1;
        state_nxt = S_MEMWR;
      end
      S_MEMWR: begin
        mem_cmd   = MEM_WRITE;
        state_nxt = S_IF1;
      end
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_RST;
      end
    endcase
  end

endmodule
